// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency FPU datapath between two pipes.
// Optional per-pipe grant and contention counters are enabled by defining FPU_ISSUE_STATS_EN.
module fpu_issue_arbiter #(
  parameter int LAT_ADDSUB = 2,
  parameter int LAT_MUL    = 2,
  parameter int LAT_DIV    = 5,
  parameter int LAT_SQRT   = 5,
  parameter int TAG_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  input  logic [2:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,
  output logic             unit_sel,
  output logic [2:0]       unit_op,
  output logic             unit_active,
  output logic             done_valid,
  output logic             done_owner,
  output logic [TAG_W-1:0] done_tag,
  output logic             busy
`ifdef FPU_ISSUE_STATS_EN
  ,
  output logic [31:0]      stat_grant0,
  output logic [31:0]      stat_grant1,
  output logic [31:0]      stat_conflict
`endif
);

  function automatic int clamp1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int L_ADDSUB = clamp1(LAT_ADDSUB);
  localparam int L_MUL    = clamp1(LAT_MUL);
  localparam int L_DIV    = clamp1(LAT_DIV);
  localparam int L_SQRT   = clamp1(LAT_SQRT);
  localparam int MAX_L    = imax(imax(L_ADDSUB, L_MUL), imax(L_DIV, L_SQRT));
  // Counter only has to hold L-2, the number of RUN cycles after the first.
  localparam int CNT_W    = (MAX_L > 2) ? $clog2(MAX_L - 1) : 1;

  function automatic int lat_of(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: lat_of = L_ADDSUB;
      3'd3:       lat_of = L_MUL;
      3'd4:       lat_of = L_DIV;
      3'd5:       lat_of = L_SQRT;
      default:    lat_of = 1;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               owner_reg, owner_next;
  logic [2:0]         op_reg, op_next;
  logic [TAG_W-1:0]   tag_reg, tag_next;
  logic               last_reg, last_next;

  logic               arb_ok, grant0, grant1, grant;
  logic [2:0]         win_op;
  logic [TAG_W-1:0]   win_tag;
  int                 win_lat;

  // Arbitration is only open while no op is mid-flight; flush and reset close it.
  assign arb_ok  = !rst && !flush && (state_reg != RUN);
  assign grant0  = arb_ok && req0_valid && (!req1_valid || last_reg);
  assign grant1  = arb_ok && req1_valid && (!req0_valid || !last_reg);
  assign grant   = grant0 || grant1;
  assign win_op  = grant1 ? req1_op  : req0_op;
  assign win_tag = grant1 ? req1_tag : req0_tag;
  assign win_lat = lat_of(win_op);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      owner_reg <= 1'b0;
      op_reg    <= 3'd0;
      tag_reg   <= '0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
      op_reg    <= op_next;
      tag_reg   <= tag_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    owner_next = owner_reg;
    op_next    = op_reg;
    tag_next   = tag_reg;
    last_next  = last_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        RUN: begin
          if (cnt_reg == '0) state_next = DONE;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        default: begin
          // DONE behaves like IDLE here so a new op can issue with no bubble.
          if (grant) begin
            owner_next = grant1;
            op_next    = win_op;
            tag_next   = win_tag;
            last_next  = grant1;
            if (win_lat == 1) begin
              state_next = DONE;
            end else begin
              state_next = RUN;
              cnt_next   = CNT_W'(win_lat - 2);
            end
          end else begin
            state_next = IDLE;
          end
        end
      endcase
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign done_valid  = (state_reg == DONE) && !flush && !rst;
  assign done_owner  = done_valid && owner_reg;
  assign done_tag    = done_valid ? tag_reg : '0;
  assign unit_active = !flush && !rst && ((state_reg != IDLE) || grant);
  assign unit_sel    = grant ? grant1 : (unit_active && owner_reg);
  assign unit_op     = grant ? win_op : (unit_active ? op_reg : 3'd0);
  assign busy        = (state_reg == RUN);

`ifdef FPU_ISSUE_STATS_EN
  logic conflict;
  assign conflict = (req0_valid && req1_valid) || (req0_valid && !grant0) ||
                    (req1_valid && !grant1);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (grant0)   stat_grant0   <= stat_grant0 + 32'd1;
      if (grant1)   stat_grant1   <= stat_grant1 + 32'd1;
      if (conflict) stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Bench for fpu_issue_arbiter: deadline-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fpu_issue_arbiter;
  localparam int TAG_W = 3;
  localparam logic [2:0] OP_OTHER = 3'd0, OP_ADD = 3'd1, OP_MUL = 3'd3, OP_DIV = 3'd4,
                         OP_SQRT = 3'd5, OP_MOVE = 3'd7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0]       req0_op = '0, req1_op = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic             req0_ready, req1_ready, unit_sel, unit_active;
  logic [2:0]       unit_op;
  logic             done_valid, done_owner, busy;
  logic [TAG_W-1:0] done_tag;
`ifdef FPU_ISSUE_STATS_EN
  logic [31:0]      stat_grant0, stat_grant1, stat_conflict;
`endif

  int checks = 0;
  int errors = 0;

  fpu_issue_arbiter #(.LAT_ADDSUB(2), .LAT_MUL(2), .LAT_DIV(5), .LAT_SQRT(5), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_tag(req0_tag), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_tag(req1_tag), .req1_ready(req1_ready),
    .unit_sel(unit_sel), .unit_op(unit_op), .unit_active(unit_active),
    .done_valid(done_valid), .done_owner(done_owner), .done_tag(done_tag), .busy(busy)
`ifdef FPU_ISSUE_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference latency table (zero would be clamped to 1; none are zero here).
  function automatic int lat(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: return 2;
      3'd3:       return 2;
      3'd4:       return 5;
      3'd5:       return 5;
      default:    return 1;
    endcase
  endfunction

  // Model: at most one outstanding op, described by its owner/tag/op and the cycle it completes.
  int               cyc_n = 0;
  bit               m_have, m_last, m_owner;
  logic [2:0]       m_op;
  logic [TAG_W-1:0] m_tag;
  int               m_done_at;
  int unsigned      m_g0, m_g1, m_conf;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_have = 0; m_last = 1; m_owner = 0; m_op = '0; m_tag = '0; m_done_at = 0;
        m_g0 = 0; m_g1 = 0; m_conf = 0;
      end else begin
        bit completing, can_arb, g0, g1, act;
        completing = m_have && (cyc_n == m_done_at);
        can_arb    = (!m_have || completing) && !flush;
        g0 = can_arb && req0_valid && (!req1_valid || m_last);
        g1 = can_arb && req1_valid && (!req0_valid || !m_last);
        act = !flush && (m_have || g0 || g1);
        chk("model_ready0", 32'(req0_ready), 32'(g0));
        chk("model_ready1", 32'(req1_ready), 32'(g1));
        chk("model_done_valid", 32'(done_valid), 32'(completing && !flush));
        if (completing && !flush) begin
          chk("model_done_owner", 32'(done_owner), 32'(m_owner));
          chk("model_done_tag", 32'(done_tag), 32'(m_tag));
        end
        chk("model_busy", 32'(busy), 32'(m_have && cyc_n < m_done_at));
        chk("model_unit_active", 32'(unit_active), 32'(act));
        if (act) begin
          chk("model_unit_sel", 32'(unit_sel), 32'(g1 ? 1'b1 : (g0 ? 1'b0 : m_owner)));
          chk("model_unit_op", 32'(unit_op), 32'((g0 || g1) ? (g1 ? req1_op : req0_op) : m_op));
        end
`ifdef FPU_ISSUE_STATS_EN
        chk("model_stat_grant0", stat_grant0, m_g0);
        chk("model_stat_grant1", stat_grant1, m_g1);
        chk("model_stat_conflict", stat_conflict, m_conf);
        if (g0) m_g0++;
        if (g1) m_g1++;
        if ((req0_valid && req1_valid) || (req0_valid && !g0) || (req1_valid && !g1)) m_conf++;
`endif
        if (flush) m_have = 0;
        else if (g0 || g1) begin
          m_have = 1; m_owner = g1; m_last = g1;
          m_op = g1 ? req1_op : req0_op;
          m_tag = g1 ? req1_tag : req0_tag;
          m_done_at = cyc_n + lat(m_op);
        end else if (completing) m_have = 0;
      end
      cyc_n++;
    end
  end

  // Drive one cycle of inputs, then return in the stable window after the falling edge.
  task automatic cyc(input logic v0, input logic [2:0] o0, input logic [TAG_W-1:0] t0,
                     input logic v1, input logic [2:0] o1, input logic [TAG_W-1:0] t1,
                     input logic fl);
    @(posedge clk); #1;
    rst = 0; flush = fl;
    req0_valid = v0; req0_op = o0; req0_tag = t0;
    req1_valid = v1; req1_op = o1; req1_tag = t1;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, OP_OTHER, 0, 0, OP_OTHER, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; flush = 0; req0_valid = 0; req1_valid = 0;
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    do_reset();
    idle();
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
    chk("rst_done_valid", 32'(done_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_unit_active", 32'(unit_active), 0);
    chk("rst_unit_op", 32'(unit_op), 0);

    // ADD from pipe 0: done two cycles after grant.
    cyc(1, OP_ADD, 3, 0, OP_OTHER, 0, 0);
    chk("add_ready0", 32'(req0_ready), 1);
    chk("add_ready1", 32'(req1_ready), 0);
    idle();
    chk("add_busy_t1", 32'(busy), 1);
    chk("add_nodone_t1", 32'(done_valid), 0);
    idle();
    chk("add_done_t2", 32'(done_valid), 1);
    chk("add_owner_t2", 32'(done_owner), 0);
    chk("add_tag_t2", 32'(done_tag), 3);
    chk("add_busy_t2", 32'(busy), 0);

    // DIV (pipe 0) vs MUL (pipe 1) from reset; MUL issues in the DIV done cycle.
    do_reset();
    cyc(1, OP_DIV, 2, 1, OP_MUL, 4, 0);
    chk("conf_ready0", 32'(req0_ready), 1);
    chk("conf_ready1", 32'(req1_ready), 0);
    chk("conf_unit_op", 32'(unit_op), 32'(OP_DIV));
    for (int i = 1; i <= 4; i++) begin
      cyc(0, OP_OTHER, 0, 1, OP_MUL, 4, 0);
      chk("div_wait_ready1", 32'(req1_ready), 0);
    end
    cyc(0, OP_OTHER, 0, 1, OP_MUL, 4, 0);
    chk("div_done", 32'(done_valid), 1);
    chk("div_done_owner", 32'(done_owner), 0);
    chk("div_done_tag", 32'(done_tag), 2);
    chk("mul_ready1", 32'(req1_ready), 1);
    chk("mul_unit_sel", 32'(unit_sel), 1);
    chk("mul_unit_op", 32'(unit_op), 32'(OP_MUL));
    idle();
    chk("mul_busy", 32'(busy), 1);
    idle();
    chk("mul_done", 32'(done_valid), 1);
    chk("mul_done_owner", 32'(done_owner), 1);
    chk("mul_done_tag", 32'(done_tag), 4);
    cyc(1, OP_OTHER, 1, 1, OP_OTHER, 6, 0);
    chk("rr_after_p1_ready0", 32'(req0_ready), 1);
    chk("rr_after_p1_ready1", 32'(req1_ready), 0);
    cyc(1, OP_OTHER, 1, 1, OP_OTHER, 6, 0);
    chk("rr_after_p0_ready1", 32'(req1_ready), 1);
    chk("rr_after_p0_ready0", 32'(req0_ready), 0);
    chk("rr_done_tag", 32'(done_tag), 1);
    idle();
    chk("rr_done_owner", 32'(done_owner), 1);
`ifdef FPU_ISSUE_STATS_EN
    chk("lit_stat_grant0", stat_grant0, 2);
    chk("lit_stat_grant1", stat_grant1, 2);
    chk("lit_stat_conflict", stat_conflict, 7);
`endif

    // MOVE from pipe 1: single-cycle op, never busy.
    cyc(0, OP_OTHER, 0, 1, OP_MOVE, 5, 0);
    chk("move_ready1", 32'(req1_ready), 1);
    chk("move_busy_t0", 32'(busy), 0);
    idle();
    chk("move_done", 32'(done_valid), 1);
    chk("move_owner", 32'(done_owner), 1);
    chk("move_tag", 32'(done_tag), 5);
    chk("move_busy_t1", 32'(busy), 0);

    // SQRT flushed at t+3; a waiting request issues at t+4.
    cyc(1, OP_SQRT, 6, 0, OP_OTHER, 0, 0);
    chk("sqrt_ready0", 32'(req0_ready), 1);
    idle();
    idle();
    cyc(0, OP_OTHER, 0, 1, OP_ADD, 1, 1);
    chk("flush_done_valid", 32'(done_valid), 0);
    chk("flush_ready1", 32'(req1_ready), 0);
    chk("flush_unit_active", 32'(unit_active), 0);
    cyc(0, OP_OTHER, 0, 1, OP_ADD, 1, 0);
    chk("post_flush_ready1", 32'(req1_ready), 1);
    idle();
    chk("post_flush_nodone", 32'(done_valid), 0);
    idle();
    chk("post_flush_done_tag", 32'(done_tag), 1);

    // Flush landing exactly in the DONE cycle.
    cyc(1, OP_OTHER, 2, 0, OP_OTHER, 0, 0);
    chk("fd_ready0", 32'(req0_ready), 1);
    cyc(0, OP_OTHER, 0, 1, OP_OTHER, 3, 1);
    chk("fd_done_valid", 32'(done_valid), 0);
    chk("fd_ready1", 32'(req1_ready), 0);
    cyc(0, OP_OTHER, 0, 1, OP_OTHER, 3, 0);
    chk("fd_after_ready1", 32'(req1_ready), 1);
    idle();
    chk("fd_after_done_tag", 32'(done_tag), 3);

    // Randomized traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), TAG_W'($urandom),
          ($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), TAG_W'($urandom),
          ($urandom_range(0, 15) == 0));
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
